// File: rtl/bp_cache_req_mux.sv
// Round-robin mux of several cache-miss request channels onto one LCE request port.
// One transaction is outstanding at a time; metadata and completion follow its owner.
module bp_cache_req_mux #(
  parameter int num_chan_p       = 2,
  parameter int req_width_p      = 64,
  parameter int metadata_width_p = 8,
  localparam int lg_num_chan_lp  = (num_chan_p > 1) ? $clog2(num_chan_p) : 1
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic [num_chan_p*req_width_p-1:0]      req_i,
  input  logic [num_chan_p-1:0]                  req_v_i,
  output logic [num_chan_p-1:0]                  req_ready_o,
  input  logic [num_chan_p*metadata_width_p-1:0] req_metadata_i,
  input  logic [num_chan_p-1:0]                  req_metadata_v_i,
  output logic [num_chan_p-1:0]                  req_complete_o,
  output logic [req_width_p-1:0]                 req_o,
  output logic                                   req_v_o,
  input  logic                                   req_ready_i,
  output logic [metadata_width_p-1:0]            req_metadata_o,
  output logic                                   req_metadata_v_o,
  input  logic                                   req_complete_i,
  output logic [lg_num_chan_lp-1:0]              owner_o,
  output logic                                   busy_o
);

  typedef enum logic [1:0] {e_ready, e_wait_meta, e_wait_complete} state_e;

  localparam logic [lg_num_chan_lp:0] num_chan_lp = (lg_num_chan_lp+1)'(num_chan_p);

  state_e                    state_q, state_d;
  logic [lg_num_chan_lp-1:0] owner_q, owner_d;
  logic [lg_num_chan_lp-1:0] rr_last_q, rr_last_d;

  logic [req_width_p-1:0]      req_arr  [num_chan_p];
  logic [metadata_width_p-1:0] meta_arr [num_chan_p];
  logic [num_chan_p-1:0]       grant_oh;
  logic [num_chan_p-1:0]       owner_oh;

  logic [lg_num_chan_lp-1:0] grant;
  logic                      found;
  logic [lg_num_chan_lp:0]   cand;

  genvar gi;
  generate
    for (gi = 0; gi < num_chan_p; gi++) begin : g_chan
      assign req_arr[gi]  = req_i[gi*req_width_p +: req_width_p];
      assign meta_arr[gi] = req_metadata_i[gi*metadata_width_p +: metadata_width_p];
      assign grant_oh[gi] = (grant == lg_num_chan_lp'(gi));
      assign owner_oh[gi] = (owner_q == lg_num_chan_lp'(gi));
    end
  endgenerate

  // Search starts just after the last winner; one conditional subtract wraps the index.
  always_comb begin
    grant = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= num_chan_p; k++) begin
      cand = {1'b0, rr_last_q} + (lg_num_chan_lp+1)'(k);
      if (cand >= num_chan_lp) cand = cand - num_chan_lp;
      if (!found && req_v_i[cand[lg_num_chan_lp-1:0]]) begin
        grant = cand[lg_num_chan_lp-1:0];
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    owner_d          = owner_q;
    rr_last_d        = rr_last_q;
    req_o            = req_arr[grant];
    req_v_o          = 1'b0;
    req_ready_o      = '0;
    req_metadata_o   = meta_arr[owner_q];
    req_metadata_v_o = 1'b0;
    req_complete_o   = '0;
    case (state_q)
      e_ready: begin
        req_v_o     = |req_v_i;
        req_ready_o = req_ready_i ? grant_oh : '0;
        if (req_v_o && req_ready_i) begin
          owner_d   = grant;
          rr_last_d = grant;
          state_d   = e_wait_meta;
        end
      end
      e_wait_meta: begin
        req_metadata_v_o = req_metadata_v_i[owner_q];
        req_complete_o   = req_complete_i ? owner_oh : '0;
        // An early completion wins over the metadata transition.
        if (req_complete_i)        state_d = e_ready;
        else if (req_metadata_v_o) state_d = e_wait_complete;
      end
      e_wait_complete: begin
        req_complete_o = req_complete_i ? owner_oh : '0;
        if (req_complete_i) state_d = e_ready;
      end
      default: state_d = e_ready;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= e_ready;
      owner_q   <= '0;
      rr_last_q <= lg_num_chan_lp'(num_chan_p - 1);
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_last_q <= rr_last_d;
    end
  end

  assign busy_o  = (state_q != e_ready);
  assign owner_o = owner_q;

endmodule

// File: tb/tb_bp_cache_req_mux.sv
// Directed bench for bp_cache_req_mux: expected grants are queued when a request
// is driven and popped when the mux fires it downstream.
module tb_bp_cache_req_mux;

  logic         clk_i = 1'b0;
  logic         reset_i;
  logic [127:0] req_i;
  logic [1:0]   req_v_i;
  logic [1:0]   req_ready_o;
  logic [15:0]  req_metadata_i;
  logic [1:0]   req_metadata_v_i;
  logic [1:0]   req_complete_o;
  logic [63:0]  req_o;
  logic         req_v_o;
  logic         req_ready_i;
  logic [7:0]   req_metadata_o;
  logic         req_metadata_v_o;
  logic         req_complete_i;
  logic [0:0]   owner_o;
  logic         busy_o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          ch;
    logic [63:0] data;
  } exp_t;
  exp_t sb[$];

  bp_cache_req_mux #(.num_chan_p(2), .req_width_p(64), .metadata_width_p(8)) dut (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .req_i            (req_i),
    .req_v_i          (req_v_i),
    .req_ready_o      (req_ready_o),
    .req_metadata_i   (req_metadata_i),
    .req_metadata_v_i (req_metadata_v_i),
    .req_complete_o   (req_complete_o),
    .req_o            (req_o),
    .req_v_o          (req_v_o),
    .req_ready_i      (req_ready_i),
    .req_metadata_o   (req_metadata_o),
    .req_metadata_v_o (req_metadata_v_o),
    .req_complete_i   (req_complete_i),
    .owner_o          (owner_o),
    .busy_o           (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] oh(input int ch);
    logic [1:0] r;
    r = (ch == 0) ? 2'b01 : 2'b10;
    return r;
  endfunction

  task automatic set_req(input int ch, input logic [63:0] d);
    if (ch == 0) req_i[63:0] = d;
    else         req_i[127:64] = d;
  endtask

  task automatic set_meta(input int ch, input logic [7:0] d);
    if (ch == 0) req_metadata_i[7:0] = d;
    else         req_metadata_i[15:8] = d;
  endtask

  task automatic expect_req(input int ch, input logic [63:0] d);
    exp_t e;
    e.ch   = ch;
    e.data = d;
    set_req(ch, d);
    sb.push_back(e);
  endtask

  // Waits (bounded) for a downstream fire and checks it against the scoreboard head.
  task automatic check_fire(input string tag);
    exp_t e;
    #1;
    for (int w = 0; w < 20 && !(req_v_o && req_ready_i); w++) tick();
    chk({tag, "_fire"}, {63'b0, req_v_o & req_ready_i}, 64'd1);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_req_o"}, req_o, e.data);
      chk({tag, "_ready_o"}, {62'b0, req_ready_o}, {62'b0, oh(e.ch)});
      tick();
      chk({tag, "_owner"}, {63'b0, owner_o}, e.ch);
      chk({tag, "_busy"}, {63'b0, busy_o}, 64'd1);
    end
  endtask

  task automatic finish_txn(input string tag, input int ch, input logic [7:0] m);
    set_meta(ch, m);
    req_metadata_v_i = oh(ch);
    #1;
    chk({tag, "_meta_v"}, {63'b0, req_metadata_v_o}, 64'd1);
    chk({tag, "_meta"}, {56'b0, req_metadata_o}, {56'b0, m});
    tick();
    req_metadata_v_i = 2'b00;
    req_complete_i   = 1'b1;
    #1;
    chk({tag, "_complete"}, {62'b0, req_complete_o}, {62'b0, oh(ch)});
    tick();
    req_complete_i = 1'b0;
  endtask

  initial begin
    reset_i          = 1'b1;
    req_i            = '0;
    req_v_i          = '0;
    req_metadata_i   = '0;
    req_metadata_v_i = '0;
    req_ready_i      = 1'b0;
    req_complete_i   = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    #1;
    chk("rst_busy", {63'b0, busy_o}, 64'd0);
    chk("rst_owner", {63'b0, owner_o}, 64'd0);
    chk("rst_req_v", {63'b0, req_v_o}, 64'd0);
    chk("rst_ready", {62'b0, req_ready_o}, 64'd0);
    chk("rst_complete", {62'b0, req_complete_o}, 64'd0);
    chk("rst_meta_v", {63'b0, req_metadata_v_o}, 64'd0);

    // Both channels request; ch0 wins first, ch1 next.
    set_req(1, 64'h22);
    expect_req(0, 64'h11);
    req_v_i     = 2'b11;
    req_ready_i = 1'b1;
    set_meta(0, 8'h3C);
    req_metadata_v_i = 2'b01;  // metadata in the fire cycle must be ignored
    #1;
    chk("fire_cycle_meta_v", {63'b0, req_metadata_v_o}, 64'd0);
    check_fire("t1_ch0");
    req_metadata_v_i = 2'b00;
    req_v_i = 2'b10;
    chk("t1_wait_req_v", {63'b0, req_v_o}, 64'd0);
    chk("t1_wait_ready", {62'b0, req_ready_o}, 64'd0);
    finish_txn("t1_ch0", 0, 8'h5A);
    expect_req(1, 64'h22);
    check_fire("t1_ch1");
    req_v_i = 2'b00;
    finish_txn("t1_ch1", 1, 8'h6B);

    // Fairness: both valid continuously.
    req_v_i = 2'b11;
    for (int n = 0; n < 6; n++) begin
      expect_req(n % 2, 64'h100 + 64'(n));
      check_fire($sformatf("fair%0d", n));
      finish_txn($sformatf("fair%0d", n), n % 2, 8'(8'h80 + n));
    end
    req_v_i = 2'b00;

    // Metadata from a non-owner channel is ignored.
    expect_req(1, 64'h33);
    req_v_i = 2'b10;
    check_fire("meta_own");
    req_v_i = 2'b00;
    set_meta(0, 8'hAA);
    req_metadata_v_i = 2'b01;
    #1;
    chk("meta_nonowner_v", {63'b0, req_metadata_v_o}, 64'd0);
    tick();
    set_meta(1, 8'h55);
    req_metadata_v_i = 2'b10;
    #1;
    chk("meta_owner_v", {63'b0, req_metadata_v_o}, 64'd1);
    chk("meta_owner_data", {56'b0, req_metadata_o}, 64'h55);
    tick();
    req_metadata_v_i = 2'b00;
    req_complete_i   = 1'b1;
    #1;
    chk("meta_own_complete", {62'b0, req_complete_o}, 64'b10);
    tick();
    req_complete_i = 1'b0;

    // Back-pressure: downstream not ready for three cycles.
    req_ready_i = 1'b0;
    expect_req(1, 64'h44);
    req_v_i = 2'b10;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("bp%0d_req_v", c), {63'b0, req_v_o}, 64'd1);
      chk($sformatf("bp%0d_ready", c), {62'b0, req_ready_o}, 64'd0);
      tick();
      chk($sformatf("bp%0d_busy", c), {63'b0, busy_o}, 64'd0);
    end
    req_ready_i = 1'b1;
    check_fire("bp");
    req_v_i = 2'b00;

    // Early complete while waiting for metadata.
    req_complete_i = 1'b1;
    #1;
    chk("early_complete", {62'b0, req_complete_o}, 64'b10);
    tick();
    req_complete_i = 1'b0;
    chk("early_busy", {63'b0, busy_o}, 64'd0);

    // Stray complete in e_ready is dropped.
    req_complete_i = 1'b1;
    #1;
    chk("stray_complete", {62'b0, req_complete_o}, 64'd0);
    tick();
    req_complete_i = 1'b0;
    chk("stray_busy", {63'b0, busy_o}, 64'd0);

    // Early complete with metadata in the same cycle still forwards metadata.
    expect_req(0, 64'h55);
    req_v_i = 2'b01;
    check_fire("early_meta");
    req_v_i = 2'b00;
    set_meta(0, 8'hC3);
    req_metadata_v_i = 2'b01;
    req_complete_i   = 1'b1;
    #1;
    chk("early_meta_v", {63'b0, req_metadata_v_o}, 64'd1);
    chk("early_meta_data", {56'b0, req_metadata_o}, 64'hC3);
    chk("early_meta_complete", {62'b0, req_complete_o}, 64'b01);
    tick();
    req_metadata_v_i = 2'b00;
    req_complete_i   = 1'b0;
    chk("early_meta_busy", {63'b0, busy_o}, 64'd0);

    // Reset in e_wait_complete clears owner and priority.
    expect_req(1, 64'h66);
    req_v_i = 2'b10;
    check_fire("rst_mid");
    req_v_i = 2'b00;
    req_metadata_v_i = 2'b10;
    tick();
    req_metadata_v_i = 2'b00;
    chk("rst_mid_pre_busy", {63'b0, busy_o}, 64'd1);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    #1;
    chk("rst_mid_busy", {63'b0, busy_o}, 64'd0);
    chk("rst_mid_owner", {63'b0, owner_o}, 64'd0);
    req_complete_i = 1'b1;
    #1;
    chk("rst_mid_late_complete", {62'b0, req_complete_o}, 64'd0);
    tick();
    req_complete_i = 1'b0;
    set_req(1, 64'h88);
    expect_req(0, 64'h77);
    req_v_i = 2'b11;
    check_fire("rst_prio");
    req_v_i = 2'b00;
    finish_txn("rst_prio", 0, 8'h11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog_timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bp_cache_req_mux.md
Name: bp_cache_req_mux

Overview:
- Multiplexes num_chan_p independent cache-miss request channels onto one LCE-side request port, using round-robin arbitration.
- Each channel has the same shape as an FE or BE cache_req interface: request, metadata and completion.
- Tracks the single outstanding transaction's owner. Forwards that owner's metadata downstream and routes the completion pulse back to the owner only.
- Sits between multi-requester cores (I$, D$, and future PTW or prefetch ports) and one shared LCE.

Parameters:
- num_chan_p, 2, number of upstream request channels (>=2).
- req_width_p, 64, width of one cache request packet.
- metadata_width_p, 8, width of one cache request metadata packet.
- lg_num_chan_lp, `BSG_SAFE_CLOG2(num_chan_p), localparam, channel index width.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- req_i  in  num_chan_p*req_width_p  per-channel request packets; channel i occupies bits [i*req_width_p +: req_width_p].
- req_v_i  in  num_chan_p  per-channel request valid.
- req_ready_o  out  num_chan_p  per-channel ready; a channel's request is accepted when its req_v_i and req_ready_o are both high.
- req_metadata_i  in  num_chan_p*metadata_width_p  per-channel metadata.
- req_metadata_v_i  in  num_chan_p  per-channel metadata valid.
- req_complete_o  out  num_chan_p  per-channel completion pulse.
- req_o  out  req_width_p  downstream request.
- req_v_o  out  1  downstream request valid.
- req_ready_i  in  1  downstream ready.
- req_metadata_o  out  metadata_width_p  downstream metadata.
- req_metadata_v_o  out  1  downstream metadata valid.
- req_complete_i  in  1  downstream completion pulse.
- owner_o  out  lg_num_chan_lp  index of the channel that owns the outstanding transaction.
- busy_o  out  1  high while a transaction is outstanding.

Behaviour:
- FSM states: e_ready, e_wait_meta, e_wait_complete. Reset state is e_ready.
- Reset values (all state cleared synchronously, including mid-transaction):
  - owner_o = 0, busy_o = 0.
  - rr_last_r = num_chan_p-1, so channel 0 has highest priority after reset.
  - All req_ready_o, req_complete_o, req_v_o and req_metadata_v_o = 0.
  - Any in-flight completion is dropped.
- Arbitration (combinational, e_ready only):
  - grant = first i with req_v_i[i], searching rr_last_r+1, rr_last_r+2, ... modulo num_chan_p.
- Outputs in e_ready:
  - req_v_o = |req_v_i.
  - req_o = req_i[grant].
  - req_ready_o[i] = req_ready_i & (i==grant).
  - All other req_ready_o are 0.
- Request fire = req_v_o & req_ready_i. On fire:
  - owner_r <= grant; rr_last_r <= grant.
  - Next state is e_wait_meta. Zero-latency pass-through.
- Outside e_ready: req_v_o = 0 and req_ready_o = 0. At most one outstanding transaction.
- e_wait_meta:
  - req_metadata_o = req_metadata_i[owner_r]; req_metadata_v_o = req_metadata_v_i[owner_r].
  - Metadata from non-owner channels is ignored.
  - On req_metadata_v_o, go to e_wait_complete.
- Metadata outside e_wait_meta: req_metadata_v_o = 0, including metadata offered in the same cycle as request fire. Channels present metadata no earlier than the cycle after acceptance.
- Completion in e_wait_complete:
  - req_complete_o[owner_r] = req_complete_i, same cycle; all other bits 0.
  - On req_complete_i, go to e_ready. A new grant is possible the next cycle.
- Completion in e_wait_meta (early complete):
  - Routed to owner the same way and FSM goes to e_ready.
  - A metadata_v in that same cycle is still forwarded.
- req_complete_i in e_ready is dropped; all req_complete_o stay 0.
- busy_o = (state != e_ready); owner_o = owner_r.
- Upstream channels must not make req_v_i depend on req_ready_o.
- Once req_v_o is high, a valid request is held until accepted. The selected channel may change only if a higher-RR-priority channel raises valid.

Test Plan:
- Reset, then ch0 req=0x11 and ch1 req=0x22 both valid, req_ready_i=1:
  - Cycle 0: req_o=0x11, req_ready_o=2'b01, owner_o=0.
  - Ch0 metadata_v, then complete → req_complete_o=2'b01.
  - Next grant is 0x22 with req_ready_o=2'b10.
- Fairness: both channels valid continuously for 6 transactions → grants alternate 0,1,0,1,0,1.
- Owner ch1 in e_wait_meta; ch0 drives metadata_v=1 with 0xAA, ch1 drives 0x55 one cycle later:
  - req_metadata_v_o is 0 in the first cycle.
  - It is 1 with 0x55 in the second cycle.
- Back-pressure: req_ready_i=0 for 3 cycles with ch1 valid:
  - req_v_o=1, req_ready_o=0 throughout, state remains e_ready.
  - Fire on the 4th cycle; owner_o=1.
- Early complete: req_complete_i in e_wait_meta → req_complete_o[owner]=1, busy_o=0 next cycle.
- Stray complete in e_ready → req_complete_o=0.
- Reset asserted in e_wait_complete → next cycle busy_o=0, owner_o=0.
  - A later req_complete_i produces no req_complete_o.
  - Ch0 has priority again.
